// File: rtl/midi_pkg.sv
// -----------------------------------------------------------------------------
// midi_pkg
// Shared types and constants for the MIDI event transmitter.
//   midi_ev_t       : event kind as presented on ev_type
//   ST_*            : upper nibble of the status byte for each event kind
//   midi_ev_entry_t : 20-bit FIFO entry {type, ch, key, val}
//   tx_state_t      : transmit FSM states (exposed on the debug output)
//   status_nibble() : maps an event kind to its status nibble
// -----------------------------------------------------------------------------
package midi_pkg;

   typedef enum logic [1:0] {
      NOTE_OFF = 2'd0,
      NOTE_ON  = 2'd1,
      CTRL     = 2'd2,
      PRG      = 2'd3
   } midi_ev_t;

   localparam logic [3:0] ST_NOTE_OFF = 4'h8;
   localparam logic [3:0] ST_NOTE_ON  = 4'h9;
   localparam logic [3:0] ST_CTRL     = 4'hB;
   localparam logic [3:0] ST_PRG      = 4'hC;

   typedef struct packed {
      midi_ev_t   ev_type;
      logic [3:0] ch;
      logic [6:0] key;
      logic [6:0] val;
   } midi_ev_entry_t;

   localparam int ENTRY_W = $bits(midi_ev_entry_t);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_SEND  = 3'd2,
      S_GUARD = 3'd3,
      S_WAIT  = 3'd4
   } tx_state_t;

   function automatic logic [3:0] status_nibble(input midi_ev_t t);
      case (t)
         NOTE_OFF: return ST_NOTE_OFF;
         NOTE_ON:  return ST_NOTE_ON;
         CTRL:     return ST_CTRL;
         default:  return ST_PRG;
      endcase
   endfunction

endpackage

// File: rtl/utils.sv
// -----------------------------------------------------------------------------
// utils
// Small shared helpers for compile-time width calculations.
//   clogb2(value) : ceil(log2(value)), 0 for value <= 1. Meant for
//                   parameter/localparam arithmetic.
// -----------------------------------------------------------------------------
package utils;

   function automatic int clogb2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) begin
            result = i + 1;
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/midi_ev_fifo.sv
// -----------------------------------------------------------------------------
// midi_ev_fifo
// Synchronous FIFO with show-ahead read data (rdata_o is the head entry
// whenever empty_o is low).
//   clk_i, rst_ni : clock, asynchronous active-low reset (empties the FIFO)
//   push_i/wdata_i: write request and data; ignored while full_o is high,
//                   even if a pop happens in the same cycle
//   pop_i         : read request; ignored while empty_o is high
//   rdata_o       : head entry
//   full_o/empty_o: status flags
// DEPTH must be a power of two >= 2. Pointers carry one extra wrap bit so
// full and empty are distinguishable when the index bits match.
// -----------------------------------------------------------------------------
module midi_ev_fifo
   import utils::*;
#(
   parameter int DEPTH = 8,
   parameter int WIDTH = 20
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int AW = clogb2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic             do_push;
   logic             do_pop;

   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;

   assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage needs no reset: entries are only read once written.
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
   end

endmodule

// File: rtl/midi_event_tx.sv
// -----------------------------------------------------------------------------
// midi_event_tx
// Encodes note/controller/program-change events into MIDI bytes and hands
// them one at a time to a MIDI UART. Events are queued in a small FIFO.
//   CLOCK_25       : system clock (rising edge)
//   iRST_N         : asynchronous active-low reset
//   ev_valid/ev_ready, ev_type, ev_key, ev_val, midi_ch : event input
//   midi_out_ready : UART transmit buffer idle
//   midi_send_byte : one-cycle load strobe for the UART
//   midi_out_data  : byte to transmit, stable from its strobe to the next
//   busy           : FIFO non-empty or a message in progress
//   dbg_state_o    : current transmit FSM state (tx_state_t encoding)
// Handshakes: an event transfers on a rising edge where ev_valid and
// ev_ready are both high; a byte transfers to the UART in any cycle where
// midi_send_byte is high, which only happens while midi_out_ready is high.
// Optional feature macro: MIDI_RUNNING_STATUS_EN -- when defined, a status
// byte equal to the last one transmitted is omitted.
// -----------------------------------------------------------------------------
module midi_event_tx
   import midi_pkg::*;
#(
   parameter int FIFO_DEPTH = 8
) (
   input  logic       CLOCK_25,
   input  logic       iRST_N,
   input  logic       ev_valid,
   output logic       ev_ready,
   input  logic [1:0] ev_type,
   input  logic [6:0] ev_key,
   input  logic [6:0] ev_val,
   input  logic [3:0] midi_ch,
   input  logic       midi_out_ready,
   output logic       midi_send_byte,
   output logic [7:0] midi_out_data,
   output logic       busy,
   output logic [2:0] dbg_state_o
);

   midi_ev_entry_t fifo_wdata;
   logic [ENTRY_W-1:0] fifo_rdata;
   logic           fifo_full;
   logic           fifo_empty;
   logic           fifo_push;
   logic           fifo_pop;

   tx_state_t      state_q, state_d;
   midi_ev_entry_t msg_q, msg_d;
   logic [1:0]     idx_q, idx_d;      // index of the next byte: 0 status, 1 key, 2 val
   logic [1:0]     last_q, last_d;    // index of the final byte of this message
   logic           guard_q, guard_d;  // second GUARD cycle marker
   logic [7:0]     data_q, data_d;    // last byte strobed to the UART
   logic [7:0]     status_byte;
   logic [7:0]     cur_byte;
   logic           send;
`ifdef MIDI_RUNNING_STATUS_EN
   logic [7:0]     rs_q, rs_d;        // last transmitted status byte, 8'h00 = none
`endif

   // Channel is captured with the event so later midi_ch changes do not
   // affect queued entries.
   assign fifo_wdata = '{ev_type: midi_ev_t'(ev_type), ch: midi_ch,
                         key: ev_key, val: ev_val};
   assign fifo_push  = ev_valid & ~fifo_full;
   assign fifo_pop   = (state_q == S_IDLE) & ~fifo_empty;

   midi_ev_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .clk_i   (CLOCK_25),
      .rst_ni  (iRST_N),
      .push_i  (fifo_push),
      .wdata_i (fifo_wdata),
      .pop_i   (fifo_pop),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign status_byte = {status_nibble(msg_q.ev_type), msg_q.ch};

   always_comb begin
      case (idx_q)
         2'd0:    cur_byte = status_byte;
         2'd1:    cur_byte = {1'b0, msg_q.key};
         default: cur_byte = {1'b0, msg_q.val};
      endcase
   end

   always_comb begin
      state_d = state_q;
      msg_d   = msg_q;
      idx_d   = idx_q;
      last_d  = last_q;
      guard_d = guard_q;
      data_d  = data_q;
      send    = 1'b0;
`ifdef MIDI_RUNNING_STATUS_EN
      rs_d    = rs_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (!fifo_empty) begin
               msg_d   = midi_ev_entry_t'(fifo_rdata);
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            last_d  = (msg_q.ev_type == PRG) ? 2'd1 : 2'd2;
            idx_d   = 2'd0;
`ifdef MIDI_RUNNING_STATUS_EN
            if (status_byte == rs_q) idx_d = 2'd1;
`endif
            state_d = S_SEND;
         end
         S_SEND: begin
            if (midi_out_ready) begin
               send    = 1'b1;
               data_d  = cur_byte;
               idx_d   = idx_q + 2'd1;
               guard_d = 1'b0;
               state_d = S_GUARD;
`ifdef MIDI_RUNNING_STATUS_EN
               if (idx_q == 2'd0) rs_d = status_byte;
`endif
            end
         end
         S_GUARD: begin
            // The UART may not drop its ready flag immediately after a load,
            // so ready is ignored for two cycles.
            if (guard_q) state_d = S_WAIT;
            else         guard_d = 1'b1;
         end
         S_WAIT: begin
            if (midi_out_ready) begin
               state_d = (idx_q > last_q) ? S_IDLE : S_SEND;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLOCK_25 or negedge iRST_N) begin
      if (!iRST_N) begin
         state_q <= S_IDLE;
         msg_q   <= '0;
         idx_q   <= 2'd0;
         last_q  <= 2'd0;
         guard_q <= 1'b0;
         data_q  <= 8'h00;
      end else begin
         state_q <= state_d;
         msg_q   <= msg_d;
         idx_q   <= idx_d;
         last_q  <= last_d;
         guard_q <= guard_d;
         data_q  <= data_d;
      end
   end

`ifdef MIDI_RUNNING_STATUS_EN
   always_ff @(posedge CLOCK_25 or negedge iRST_N) begin
      if (!iRST_N) rs_q <= 8'h00;
      else         rs_q <= rs_d;
   end
`endif

   // The byte is presented combinationally in the strobe cycle and held in
   // data_q afterwards, so the output only changes at a strobe.
   assign midi_send_byte = send;
   assign midi_out_data  = send ? cur_byte : data_q;
   assign ev_ready       = ~fifo_full;
   assign busy           = ~fifo_empty | (state_q != S_IDLE);
   assign dbg_state_o    = state_q;

endmodule
